// File: rtl/doc_pkg.sv
// rtl/doc_pkg.sv - shared constants and FSM state type for the DOC host responder
package doc_pkg;

  localparam logic [7:0] DOC_E0_ADDR = 8'hE0;
  localparam int         DOC_NUM_OSC = 32;
  localparam int         DOC_OSC_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_DATA,
    ST_HOST_WR,
    ST_PREFETCH,
    ST_PREFETCH_DATA
  } state_e;

endpackage

// File: rtl/doc_regfile.sv
// rtl/doc_regfile.sv - 256x8 DOC register file, one sync write port, registered and combinational read ports
module doc_regfile (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [7:0] raddr_b_i,
  output logic [7:0] rdata_b_o
);

  logic [7:0] mem_q [256];
  logic [7:0] rdata_a_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Write-first: a write landing this edge is what port A returns.
  always_ff @(posedge clk) begin
    if (reset)                             rdata_a_q <= 8'h00;
    else if (we_i && waddr_i == raddr_a_i) rdata_a_q <= wdata_i;
    else                                   rdata_a_q <= mem_q[raddr_a_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/doc_host_responder.sv
// rtl/doc_host_responder.sv - DOC regfile owner, sound-RAM arbiter, host prefetch and E0 interrupt state
module doc_host_responder
  import doc_pkg::*;
#(
  parameter logic [7:0] E0_ADDR = DOC_E0_ADDR,
  parameter int         NUM_OSC = DOC_NUM_OSC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        doc_enable_i,
  input  logic        ram_access_i,
  input  logic [15:0] sound_addr_i,
  input  logic [7:0]  sound_data_out_i,
  input  logic        doc_host_en_i,
  input  logic        doc_wr_i,
  input  logic        ram_wr_i,
  output logic [7:0]  sound_data_in_o,
  input  logic [7:0]  eng_raddr_i,
  output logic [7:0]  eng_rdata_o,
  input  logic        eng_we_i,
  input  logic [7:0]  eng_waddr_i,
  input  logic [7:0]  eng_wdata_i,
  input  logic        irq_set_i,
  input  logic [4:0]  irq_osc_i,
  output logic        irq_o,
  input  logic        fetch_req_i,
  input  logic [15:0] fetch_addr_i,
  output logic        fetch_grant_o,
  output logic [7:0]  fetch_data_o,
  output logic [15:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i
);

  state_e               state_q, state_d;
  logic [7:0]           sd_q, sd_d;
  logic                 pf_pend_q, pf_pend_d;
  logic                 lat_v_q;
  logic [15:0]          lat_addr_q;
  logic [7:0]           lat_data_q;
  logic                 eb_v_q;
  logic [7:0]           eb_addr_q, eb_data_q;
  logic [NUM_OSC-1:0]   pend_q, pend_d, set_mask, clr_mask;
  logic [DOC_OSC_W-1:0] low_osc;
  logic [7:0]           reg_addr, reg_rdata, reg_val;
  logic                 host_we, rf_we, e0_clr, we_raw, lat_clr, pf_take;
  logic [7:0]           rf_waddr, rf_wdata;

  assign reg_addr = sound_addr_i[7:0];
  assign host_we  = doc_wr_i && (reg_addr != E0_ADDR);

  // Host owns the write port; a displaced engine write waits one cycle in eb_*.
  always_comb begin
    rf_we    = 1'b1;
    rf_waddr = reg_addr;
    rf_wdata = sound_data_out_i;
    if (!host_we) begin
      if (eb_v_q) begin
        rf_waddr = eb_addr_q;
        rf_wdata = eb_data_q;
      end else if (eng_we_i) begin
        rf_waddr = eng_waddr_i;
        rf_wdata = eng_wdata_i;
      end else begin
        rf_we = 1'b0;
      end
    end
  end

  doc_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (eng_raddr_i),
    .rdata_a_o (eng_rdata_o),
    .raddr_b_i (reg_addr),
    .rdata_b_o (reg_rdata)
  );

  always_comb begin
    low_osc = '1;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (pend_q[i]) low_osc = DOC_OSC_W'(i);
    end
  end

  assign irq_o    = |pend_q;
  assign reg_val  = (reg_addr == E0_ADDR) ? {~irq_o, 1'b1, low_osc, 1'b1} : reg_rdata;
  assign e0_clr   = doc_host_en_i && !doc_wr_i && (reg_addr == E0_ADDR);
  assign set_mask = irq_set_i ? (NUM_OSC'(1) << irq_osc_i) : '0;
  assign clr_mask = e0_clr ? (NUM_OSC'(1) << low_osc) : '0;
  assign pend_d   = (pend_q & ~clr_mask) | set_mask;

  always_comb begin
    state_d       = state_q;
    sd_d          = sd_q;
    fetch_grant_o = 1'b0;
    fetch_data_o  = 8'h00;
    mem_addr_o    = 16'h0000;
    mem_wdata_o   = 8'h00;
    we_raw        = 1'b0;
    lat_clr       = 1'b0;
    pf_take       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req_i)                     state_d = ST_FETCH;
        else if (lat_v_q)                    state_d = ST_HOST_WR;
        else if (doc_enable_i || pf_pend_q) begin
          state_d = ST_PREFETCH;
          pf_take = 1'b1;
        end
      end
      ST_FETCH: begin
        mem_addr_o = fetch_addr_i;
        state_d    = ST_FETCH_DATA;
      end
      ST_FETCH_DATA: begin
        fetch_grant_o = 1'b1;
        fetch_data_o  = mem_rdata_i;
        state_d       = ST_IDLE;
      end
      ST_HOST_WR: begin
        mem_addr_o  = lat_addr_q;
        mem_wdata_o = lat_data_q;
        we_raw      = 1'b1;
        lat_clr     = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_PREFETCH: begin
        if (ram_access_i) begin
          mem_addr_o = sound_addr_i;
          state_d    = ST_PREFETCH_DATA;
        end else begin
          sd_d    = reg_val;
          state_d = ST_IDLE;
        end
      end
      ST_PREFETCH_DATA: begin
        sd_d    = mem_rdata_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset must suppress a write already presented in the HOST_WR cycle.
  assign mem_we_o        = we_raw && !reset;
  assign pf_pend_d       = (pf_pend_q || doc_enable_i) && !pf_take;
  assign sound_data_in_o = sd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sd_q      <= 8'h00;
      pf_pend_q <= 1'b0;
      pend_q    <= '0;
      lat_v_q   <= 1'b0;
      eb_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sd_q      <= sd_d;
      pf_pend_q <= pf_pend_d;
      pend_q    <= pend_d;
      if (ram_wr_i)     lat_v_q <= 1'b1;
      else if (lat_clr) lat_v_q <= 1'b0;
      if ((host_we || eb_v_q) && eng_we_i) eb_v_q <= 1'b1;
      else if (!host_we)                   eb_v_q <= 1'b0;
      else if (eb_addr_q == reg_addr)      eb_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr_i) begin
      lat_addr_q <= sound_addr_i;
      lat_data_q <= sound_data_out_i;
    end
    if ((host_we || eb_v_q) && eng_we_i) begin
      eb_addr_q <= eng_waddr_i;
      eb_data_q <= eng_wdata_i;
    end
  end

endmodule

// File: tb/tb_doc_host_responder.sv
// tb/tb_doc_host_responder.sv - directed self-checking bench for doc_host_responder
module tb_doc_host_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        doc_enable, ram_access, doc_host_en, doc_wr, ram_wr;
  logic [15:0] sound_addr;
  logic [7:0]  sound_data_out, sound_data_in;
  logic [7:0]  eng_raddr, eng_rdata, eng_waddr, eng_wdata;
  logic        eng_we, irq_set, irq, fetch_req, fetch_grant, mem_we;
  logic [4:0]  irq_osc;
  logic [15:0] fetch_addr, mem_addr;
  logic [7:0]  fetch_data, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  doc_host_responder dut (
    .clk              (clk),
    .reset            (reset),
    .doc_enable_i     (doc_enable),
    .ram_access_i     (ram_access),
    .sound_addr_i     (sound_addr),
    .sound_data_out_i (sound_data_out),
    .doc_host_en_i    (doc_host_en),
    .doc_wr_i         (doc_wr),
    .ram_wr_i         (ram_wr),
    .sound_data_in_o  (sound_data_in),
    .eng_raddr_i      (eng_raddr),
    .eng_rdata_o      (eng_rdata),
    .eng_we_i         (eng_we),
    .eng_waddr_i      (eng_waddr),
    .eng_wdata_i      (eng_wdata),
    .irq_set_i        (irq_set),
    .irq_osc_i        (irq_osc),
    .irq_o            (irq),
    .fetch_req_i      (fetch_req),
    .fetch_addr_i     (fetch_addr),
    .fetch_grant_o    (fetch_grant),
    .fetch_data_o     (fetch_data),
    .mem_addr_o       (mem_addr),
    .mem_we_o         (mem_we),
    .mem_wdata_o      (mem_wdata),
    .mem_rdata_i      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Sound-RAM model plus event recorder.
  logic [7:0]  ram [65536];
  int          cyc = 0, we_cnt = 0, grant_cnt = 0, last_we_cyc = 0, last_grant_cyc = 0;
  logic [15:0] last_we_addr = 16'h0;
  logic [7:0]  last_we_data = 8'h0;

  always @(posedge clk) begin
    if (reset)       ram[16'h2000] <= 8'h77;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fetch_grant) begin
      grant_cnt      = grant_cnt + 1;
      last_grant_cyc = cyc;
    end
    if (mem_we) begin
      we_cnt       = we_cnt + 1;
      last_we_cyc  = cyc;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
    bit          via_pf;
  } vec_t;

  vec_t vt [7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [15:0] a, input logic [7:0] d);
    sound_addr = a; sound_data_out = d; doc_wr = 1'b1;
    tick();
    doc_wr = 1'b0;
  endtask

  task automatic prefetch(input logic [15:0] a, input logic ram_sel);
    sound_addr = a; ram_access = ram_sel; doc_enable = 1'b1;
    tick();
    doc_enable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_irq(input logic [4:0] osc);
    irq_set = 1'b1; irq_osc = osc;
    tick();
    irq_set = 1'b0;
  endtask

  task automatic e0_clear();
    sound_addr = 16'h00E0; doc_host_en = 1'b1;
    tick();
    doc_host_en = 1'b0;
  endtask

  int  we_base, gr_base, lat;
  bit  ok;

  initial begin
    vt[0] = '{16'h0040, 8'h5A, 8'h5A, 1'b0};
    vt[1] = '{16'h0000, 8'h11, 8'h11, 1'b0};
    vt[2] = '{16'h00FF, 8'hEE, 8'hEE, 1'b0};
    vt[3] = '{16'h3F41, 8'hA5, 8'hA5, 1'b0};
    vt[4] = '{16'hFF10, 8'hC7, 8'hC7, 1'b0};
    vt[5] = '{16'h0042, 8'h3C, 8'h3C, 1'b1};
    vt[6] = '{16'h00E0, 8'h33, 8'hFF, 1'b1};

    reset = 1'b1; doc_enable = 0; ram_access = 0; doc_host_en = 0; doc_wr = 0; ram_wr = 0;
    sound_addr = 0; sound_data_out = 0; eng_raddr = 0; eng_we = 0; eng_waddr = 0; eng_wdata = 0;
    irq_set = 0; irq_osc = 0; fetch_req = 0; fetch_addr = 0;
    repeat (3) tick();
    check("rst_sound_data_in", sound_data_in, 8'h00);
    check("rst_eng_rdata", eng_rdata, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_fetch_grant", fetch_grant, 1'b0);
    reset = 1'b0;
    tick();

    foreach (vt[i]) host_write(vt[i].addr, vt[i].wdata);
    foreach (vt[i]) begin
      if (vt[i].via_pf) begin
        prefetch(vt[i].addr, 1'b0);
        check($sformatf("vec%0d_prefetch", i), sound_data_in, vt[i].exp);
      end else begin
        eng_raddr = vt[i].addr[7:0];
        tick(); tick();
        check($sformatf("vec%0d_eng_rdata", i), eng_rdata, vt[i].exp);
      end
    end

    // Engine/host collision: engine write lands one cycle after the host write.
    host_write(16'h0080, 8'hAA);
    eng_we = 1'b1; eng_waddr = 8'h80; eng_wdata = 8'h01;
    doc_wr = 1'b1; sound_addr = 16'h0081; sound_data_out = 8'h02; eng_raddr = 8'h80;
    tick();
    eng_we = 1'b0; doc_wr = 1'b0;
    check("coll_80_not_yet", eng_rdata, 8'hAA);
    tick();
    check("coll_80_landed", eng_rdata, 8'h01);
    eng_raddr = 8'h81;
    tick();
    check("coll_81", eng_rdata, 8'h02);
    eng_we = 1'b1; eng_waddr = 8'h90; eng_wdata = 8'h01;
    doc_wr = 1'b1; sound_addr = 16'h0091; sound_data_out = 8'h02;
    tick();
    eng_we = 1'b0;
    sound_addr = 16'h0090; sound_data_out = 8'h77;
    tick();
    doc_wr = 1'b0; eng_raddr = 8'h90;
    tick(); tick();
    check("later_host_wins", eng_rdata, 8'h77);

    // RAM prefetch must deliver within 3 cycles.
    sound_addr = 16'h2000; ram_access = 1'b1; doc_enable = 1'b1; ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      doc_enable = 1'b0;
      if (sound_data_in == 8'h77) ok = 1'b1;
    end
    check("ram_prefetch", ok, 1'b1);
    ram_access = 1'b0;
    repeat (2) tick();

    // Host RAM write contending with a held fetch request.
    we_base = we_cnt; gr_base = grant_cnt; lat = -1;
    fetch_req = 1'b1; fetch_addr = 16'h2000;
    ram_wr = 1'b1; sound_addr = 16'h1234; sound_data_out = 8'hC3;
    for (int i = 1; i <= 10; i++) begin
      tick();
      ram_wr = 1'b0;
      if (fetch_grant && lat < 0) begin
        lat = i;
        check("fetch_data", fetch_data, 8'h77);
        fetch_req = 1'b0;
      end
    end
    fetch_req = 1'b0;
    check("fetch_latency", lat, 2);
    check("grant_count", grant_cnt - gr_base, 1);
    check("host_we_count", we_cnt - we_base, 1);
    check("host_we_addr", last_we_addr, 16'h1234);
    check("host_we_data", last_we_data, 8'hC3);
    check("grant_before_we", last_we_cyc > last_grant_cyc, 1'b1);

    // E0 interrupt register.
    set_irq(5'd3);
    set_irq(5'd7);
    check("irq_set", irq, 1'b1);
    prefetch(16'h00E0, 1'b0);
    check("e0_3_7", sound_data_in, 8'h47);
    e0_clear();
    prefetch(16'h00E0, 1'b0);
    check("e0_7", sound_data_in, 8'h4F);
    e0_clear();
    prefetch(16'h00E0, 1'b0);
    check("e0_none", sound_data_in, 8'hFF);
    check("irq_clear", irq, 1'b0);
    set_irq(5'd5);
    irq_set = 1'b1; irq_osc = 5'd5; e0_clear(); irq_set = 1'b0;
    prefetch(16'h00E0, 1'b0);
    check("e0_set_wins", sound_data_in, 8'h4B);
    irq_set = 1'b1; irq_osc = 5'd2; e0_clear(); irq_set = 1'b0;
    prefetch(16'h00E0, 1'b0);
    check("e0_clr_other_set", sound_data_in, 8'h45);
    e0_clear();
    check("irq_empty", irq, 1'b0);

    // Reset arriving in the HOST_WR cycle.
    set_irq(5'd1);
    we_base = we_cnt;
    ram_wr = 1'b1; sound_addr = 16'h5555; sound_data_out = 8'h99;
    tick();
    ram_wr = 1'b0;
    tick();
    check("in_host_wr", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_host_wr_we", mem_we, 1'b0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_no_write", we_cnt - we_base, 0);
    check("rst_irq_low", irq, 1'b0);
    check("rst_mem_addr_idle", mem_addr, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
